ahb_slave_mem: RTL and testbench

//  AHB-Lite memory-mapped responder: the slave end that sources hrdata/hreadyout/hresp

---
 rtl/ahb_slave_mem_if.sv | 26 ++
 rtl/ahb_slave_mem.sv | 172 +++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-slot bundle: address/control/write data in, ready/response/read data out.
// Latency: none, wires only.
// Backpressure: hready/hreadyout carry the wait-state handshake between fabric and slave.
interface ahb_slave_mem_if;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   // Master side includes the decoder and the hready return path of the fabric.
   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: flop word array, byte/halfword/word access, two-cycle ERROR.
// Latency: legal data phase is WAIT_STATES+1 cycles, illegal data phase is 2 cycles.
// Backpressure: hreadyout low during wait states and the first ERROR cycle; otherwise pipelined accept.
module ahb_slave_mem #(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic           hclk,
   input  logic           hresetn,
   ahb_slave_mem_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ERR1,
      S_ERR2
   } state_t;

   // Everything the data phase needs, captured in the address phase.
   // Only legal transfers set vld, so illegal ones can never touch memory.
   typedef struct packed {
      logic          vld;
      logic          wr;
      logic [1:0]    size;
      logic [1:0]    lane;
      logic [AW-1:0] idx;
   } dphase_t;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  cnt;
   logic [2:0]  cnt_nxt;
   dphase_t     dp;
   logic [31:0] mem [DEPTH];

   logic        rdy;
   logic        err;
   logic        accept;
   logic        size_ok;
   logic        aligned;
   logic        in_range;
   logic        legal;
   logic        complete;
   logic [3:0]  be;
   logic        unused_ok;

   // htrans[0] only separates IDLE/BUSY and NONSEQ/SEQ, which this slave treats alike.
   assign unused_ok = bus.htrans[0];

   assign accept   = bus.hsel & bus.hready & bus.htrans[1];
   assign size_ok  = (bus.hsize <= 3'd2);
   assign in_range = ({2'b00, bus.haddr[31:2]} < 32'(DEPTH));
   assign legal    = size_ok & aligned & in_range;

   // Natural alignment of the requested size; illegal sizes are caught by size_ok.
   always_comb begin
      aligned = 1'b1;
      case (bus.hsize)
         3'd1:    aligned = ~bus.haddr[0];
         3'd2:    aligned = (bus.haddr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   // State and wait counter register.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state <= S_IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state and the ready/response outputs that depend only on state.
   // ERR2 doubles as an accept slot so an error does not cost the pipeline a bubble.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rdy       = 1'b1;
      err       = 1'b0;
      unique case (state)
         S_IDLE, S_ERR2: begin
            err = (state == S_ERR2);
            if (accept) begin
               if (!legal) begin
                  state_nxt = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = 3'(WAIT_STATES);
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            rdy     = 1'b0;
            cnt_nxt = cnt - 3'd1;
            if (cnt == 3'd1) begin
               state_nxt = S_IDLE;
            end
         end
         S_ERR1: begin
            rdy       = 1'b0;
            err       = 1'b1;
            state_nxt = S_ERR2;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Address-phase capture; only advances when this slave is ready, so a stalled
   // data phase keeps its captured fields.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         dp <= '0;
      end else if (rdy) begin
         dp.vld <= accept & legal;
         if (accept) begin
            dp.wr   <= bus.hwrite;
            dp.size <= bus.hsize[1:0];
            dp.lane <= bus.haddr[1:0];
            dp.idx  <= bus.haddr[AW+1:2];
         end
      end
   end

   // A legal data phase ends in the first ready cycle after its accept.
   assign complete = dp.vld & rdy;

   // Little-endian byte enables from captured size and lane.
   always_comb begin
      be = 4'b0000;
      case (dp.size)
         2'd0:    be = 4'b0001 << dp.lane;
         2'd1:    be = dp.lane[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   // Memory write at the edge ending the completing cycle. Reset clears dp.vld
   // asynchronously, so a write interrupted by reset never commits.
   always_ff @(posedge hclk) begin
      if (complete && dp.wr) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[dp.idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
         end
      end
   end

   assign bus.hreadyout = rdy;
   assign bus.hresp     = err;
   // Full word regardless of size; zero outside a completing read.
   assign bus.hrdata    = (complete && !dp.wr) ? mem[dp.idx] : 32'h0;

   // ERROR is always the two-cycle sequence: stalled ERROR, then ready ERROR.
   a_err_two_cycle: assert property (@(posedge hclk) disable iff (!hresetn)
      (err && !rdy) |=> (err && rdy));

   // A wait state always has at least one cycle left to count.
   a_wait_cnt: assert property (@(posedge hclk) disable iff (!hresetn)
      (state == S_WAIT) |-> (cnt != 3'd0));
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (one wait state, zero wait states) on separate slots.
// Latency: expected responses are queued at accept and checked when the data phase completes.
// Backpressure: driver holds each address phase until the selected slave is ready.
module tb_ahb_slave_mem;
   localparam int DEPTH = 256;
   localparam int WS0   = 0;
   localparam int WS1   = 1;

   typedef struct {
      int          id;
      logic        resp;
      logic        chk_data;
      logic [31:0] rdata;
      int          waits;
   } exp_t;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        act;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;

   logic        mrdy;
   logic        mresp;
   logic [31:0] mdat;

   int          checks = 0;
   int          errors = 0;
   int          seq    = 0;
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic        dp_on  = 1'b0;
   int          wcnt   = 0;
   logic [31:0] mdl [2][DEPTH];

   always #5 hclk = ~hclk;

   ahb_slave_mem_if bus0 ();
   ahb_slave_mem_if bus1 ();

   assign bus0.hsel   = hsel & ~act;
   assign bus0.haddr  = haddr;
   assign bus0.htrans = htrans;
   assign bus0.hwrite = hwrite;
   assign bus0.hsize  = hsize;
   assign bus0.hwdata = hwdata;
   assign bus0.hready = bus0.hreadyout;

   assign bus1.hsel   = hsel & act;
   assign bus1.haddr  = haddr;
   assign bus1.htrans = htrans;
   assign bus1.hwrite = hwrite;
   assign bus1.hsize  = hsize;
   assign bus1.hwdata = hwdata;
   assign bus1.hready = bus1.hreadyout;

   assign mrdy  = act ? bus1.hreadyout : bus0.hreadyout;
   assign mresp = act ? bus1.hresp     : bus0.hresp;
   assign mdat  = act ? bus1.hrdata    : bus0.hrdata;

   ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus0.slave)
   );

   ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus1.slave)
   );

   task automatic check(input string nm, input int id, input logic [31:0] actual,
                        input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("FAIL %s id=%0d actual=%h required=%h", nm, id, actual, required);
      end
   endtask

   function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
      if (sz > 3'd2) return 1'b0;
      if ((a % (32'd1 << sz)) != 0) return 1'b0;
      if ((a >> 2) >= DEPTH) return 1'b0;
      return 1'b1;
   endfunction

   task automatic mdl_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] wd);
      int nb;
      int lo;
      int w;
      nb = 1 << sz;
      lo = int'(a % 4);
      w  = int'(a >> 2);
      for (int b = lo; b < lo + nb; b++) begin
         mdl[d][w][8*b +: 8] = wd[8*b +: 8];
      end
   endtask

   // Present one address phase, wait for it to be taken, then queue its expected response.
   task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input bit use_want, input logic [31:0] want);
      exp_t e;
      int   n;
      int   d;
      hsel   = 1'b1;
      htrans = 2'b10;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
      n      = 0;
      @(negedge hclk);
      while (!mrdy && n < 64) begin
         @(negedge hclk);
         n++;
      end
      check("accept_timeout", seq, 32'(mrdy), 32'd1);
      @(posedge hclk);
      #1;
      hwdata = wd;
      hsel   = 1'b0;
      htrans = 2'b00;
      d      = act ? 1 : 0;
      e.id       = seq;
      seq++;
      e.resp     = !legal(a, sz);
      e.chk_data = 1'b0;
      e.rdata    = 32'h0;
      e.waits    = e.resp ? 1 : (act ? WS1 : WS0);
      if (!e.resp) begin
         e.chk_data = 1'b1;
         if (w) mdl_write(d, a, sz, wd);
         else   e.rdata = use_want ? want : mdl[d][int'(a >> 2)];
      end
      exp_q.push_back(e);
   endtask

   // Non-transfer cycles: kind 0 deselected, 1 IDLE, 2 BUSY.
   task automatic gap(input int n, input int kind);
      hsel   = (kind != 0);
      htrans = (kind == 2) ? 2'b01 : 2'b00;
      haddr  = $urandom;
      hwrite = 1'($urandom_range(0, 1));
      hsize  = 3'($urandom_range(0, 7));
      repeat (n) begin
         @(posedge hclk);
         #1;
      end
      hsel   = 1'b0;
      htrans = 2'b00;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || dp_on) && n < 100) begin
         @(posedge hclk);
         #1;
         n++;
      end
      check("drain_timeout", -1, 32'(exp_q.size() == 0 && !dp_on), 32'd1);
   endtask

   task automatic async_reset(input string tag);
      hsel    = 1'b0;
      htrans  = 2'b00;
      hresetn = 1'b0;
      #1;
      check({tag, "_rst_rdy"},  -1, 32'(mrdy),  32'd1);
      check({tag, "_rst_resp"}, -1, 32'(mresp), 32'd0);
      check({tag, "_rst_data"}, -1, mdat,       32'h0);
      @(posedge hclk);
      @(posedge hclk);
      #2;
      hresetn = 1'b1;
   endtask

   task automatic rand_run(input int n);
      logic [31:0] a;
      logic [2:0]  sz;
      int          idx;
      int          lane;
      int          r;
      for (int i = 0; i < n; i++) begin
         r    = $urandom_range(0, 19);
         sz   = (r == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         idx  = ($urandom_range(0, 7) == 0) ? DEPTH - 1 : $urandom_range(0, 15);
         lane = $urandom_range(0, 3);
         if (sz == 3'd1)      lane = lane & 2;
         else if (sz == 3'd2) lane = 0;
         a = 32'(idx * 4 + lane);
         if (r == 1)      a = a ^ 32'd1;
         else if (r == 2) a = a + 32'(DEPTH * 4);
         issue(a, 1'($urandom_range(0, 1)), sz, $urandom, 1'b0, 32'h0);
         if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3), $urandom_range(0, 2));
      end
   endtask

   // Monitor: checks every cycle of the selected slot against the queued expectations.
   always @(negedge hclk) begin
      if (!hresetn) begin
         dp_on = 1'b0;
         wcnt  = 0;
         exp_q.delete();
      end else begin
         if (dp_on) begin
            if (exp_q.size() == 0) begin
               check("no_expectation", -1, 32'd0, 32'd1);
            end else if (!mrdy) begin
               wcnt++;
               check("wait_resp", exp_q[0].id, 32'(mresp), 32'(exp_q[0].resp));
               check("wait_data", exp_q[0].id, mdat, 32'h0);
            end else begin
               mon_e = exp_q.pop_front();
               check("resp",  mon_e.id, 32'(mresp), 32'(mon_e.resp));
               check("waits", mon_e.id, 32'(wcnt),  32'(mon_e.waits));
               if (mon_e.chk_data) check("rdata", mon_e.id, mdat, mon_e.rdata);
               wcnt = 0;
            end
         end else begin
            check("idle_rdy",  -1, 32'(mrdy),  32'd1);
            check("idle_resp", -1, 32'(mresp), 32'd0);
            check("idle_data", -1, mdat,       32'h0);
         end
         if (mrdy) dp_on = hsel && htrans[1];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] saved;
      hresetn = 1'b0;
      act     = 1'b1;
      hsel    = 1'b0;
      htrans  = 2'b00;
      haddr   = 32'h0;
      hwrite  = 1'b0;
      hsize   = 3'd0;
      hwdata  = 32'h0;
      #12;
      check("por_rdy1",  -1, 32'(bus1.hreadyout), 32'd1);
      check("por_resp1", -1, 32'(bus1.hresp),     32'd0);
      check("por_data1", -1, bus1.hrdata,         32'h0);
      check("por_rdy0",  -1, 32'(bus0.hreadyout), 32'd1);
      @(posedge hclk);
      #2;
      hresetn = 1'b1;

      // Give every word the random traffic can read a known value.
      for (int d = 1; d >= 0; d--) begin
         act = 1'(d);
         for (int i = 0; i <= 16; i++) begin
            issue(32'((i < 16 ? i : DEPTH - 1) * 4), 1'b1, 3'd2, $urandom, 1'b0, 32'h0);
         end
         drain();
      end

      // One wait state: word write then read, byte and halfword merges.
      act = 1'b1;
      issue(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
      issue(32'h10, 1'b0, 3'd2, 32'h0,        1'b1, 32'hDEADBEEF);
      issue(32'h13, 1'b1, 3'd0, 32'hAA000000, 1'b0, 32'h0);
      issue(32'h10, 1'b0, 3'd2, 32'h0,        1'b1, 32'hAAADBEEF);
      issue(32'h10, 1'b1, 3'd1, 32'h00001234, 1'b0, 32'h0);
      issue(32'h10, 1'b0, 3'd2, 32'h0,        1'b1, 32'hAAAD1234);

      // Illegal accesses, then readback of the words they point at.
      issue(32'h400, 1'b0, 3'd2, 32'h0,        1'b0, 32'h0);
      issue(32'h02,  1'b1, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0);
      issue(32'h10,  1'b1, 3'd3, 32'hCAFEF00D, 1'b0, 32'h0);
      issue(32'h00,  1'b0, 3'd2, 32'h0,        1'b0, 32'h0);
      issue(32'h10,  1'b0, 3'd2, 32'h0,        1'b1, 32'hAAAD1234);
      drain();

      // Async reset in the completing cycle of a read.
      issue(32'h10, 1'b0, 3'd2, 32'h0, 1'b1, 32'hAAAD1234);
      @(posedge hclk);
      #2;
      check("rr_rdy",  -1, 32'(mrdy), 32'd1);
      check("rr_data", -1, mdat,      32'hAAAD1234);
      async_reset("rr");

      rand_run(150);
      drain();

      // Zero wait states: back-to-back write/read, then non-transfer cycles.
      act = 1'b0;
      issue(32'h20, 1'b1, 3'd2, 32'h5A5A5A5A, 1'b0, 32'h0);
      issue(32'h20, 1'b0, 3'd2, 32'h0,        1'b1, 32'h5A5A5A5A);
      gap(3, 0);
      gap(3, 1);
      gap(2, 2);
      drain();
      rand_run(150);
      drain();

      // Reset during the wait state of a write: the old word must survive.
      act = 1'b1;
      issue(32'h30, 1'b1, 3'd2, 32'h11111111, 1'b0, 32'h0);
      drain();
      saved = mdl[1][12];
      issue(32'h30, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, 32'h0);
      mdl[1][12] = saved;
      #2;
      check("t6_in_wait", -1, 32'(mrdy), 32'd0);
      async_reset("t6");
      issue(32'h30, 1'b0, 3'd2, 32'h0, 1'b1, 32'h11111111);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
